// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester front end:
// control codes, arbiter FSM encoding and the legal-code check.
package alu_pkg;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_XOR = 4'b0011;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SHL = 4'b1000;
    localparam logic [3:0] CTL_SHR = 4'b1001;
    localparam logic [3:0] CTL_SRA = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for the eight codes the ALU implements.
    function automatic logic ctl_is_legal(input logic [3:0] ctl);
        case (ctl)
            CTL_AND, CTL_OR, CTL_ADD, CTL_XOR,
            CTL_SUB, CTL_SHL, CTL_SHR, CTL_SRA: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// The shared 32-bit combinational ALU. Shifts use the low five bits
// of operand2; unknown codes produce 0.
module ALU
    import alu_pkg::*;
(
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [3:0]  ALUControl,
    output logic [31:0] result,
    output logic        zero,
    output logic        neg
);

    // Operation select and flag generation.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        result = '0;
        case (ALUControl)
            CTL_AND: result = operand1 & operand2;
            CTL_OR:  result = operand1 | operand2;
            CTL_ADD: result = operand1 + operand2;
            CTL_XOR: result = operand1 ^ operand2;
            CTL_SUB: result = operand1 - operand2;
            CTL_SHL: result = operand1 << operand2[4:0];
            CTL_SHR: result = operand1 >> operand2[4:0];
            CTL_SRA: result = $unsigned($signed(operand1) >>> operand2[4:0]);
            default: result = '0;
        endcase
        zero = (result == '0);
        neg  = result[31];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU. Round-robin grant in IDLE, one cycle of
// execution from registered operands, then the response is held for the
// owner until it is consumed. One operation in flight at a time.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          CHECK_CTL = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [WIDTH-1:0] i_req0_operand1,
    input  logic [WIDTH-1:0] i_req0_operand2,
    input  logic [3:0]       i_req0_ALUControl,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req1_operand1,
    input  logic [WIDTH-1:0] i_req1_operand2,
    input  logic [3:0]       i_req1_ALUControl,
    output logic             o_rsp0_valid,
    input  logic             i_rsp0_ready,
    output logic [WIDTH-1:0] o_rsp0_result,
    output logic             o_rsp0_zero,
    output logic             o_rsp0_neg,
    output logic             o_rsp0_err,
    output logic             o_rsp1_valid,
    input  logic             i_rsp1_ready,
    output logic [WIDTH-1:0] o_rsp1_result,
    output logic             o_rsp1_zero,
    output logic             o_rsp1_neg,
    output logic             o_rsp1_err,
    output logic             o_busy
);

    state_t             state_q, state_d;
    logic               last_q;     // requester served most recently
    logic               owner_q;    // requester owning the op in flight
    logic [WIDTH-1:0]   op1_q, op2_q;
    logic [3:0]         ctl_q;
    logic [WIDTH-1:0]   res_q;
    logic               zero_q, neg_q, err_q;

    logic               grant_id, accept, rsp_fire, trap;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_zero, alu_neg;

    // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_id = (i_req0_valid && i_req1_valid) ? ~last_q : i_req1_valid;
        // NOTE: ready is gated by i_rst_n so every output reads 0 while reset is held.
        accept   = i_rst_n && (state_q == ST_IDLE) && (i_req0_valid || i_req1_valid);
        rsp_fire = (state_q == ST_RESP) && (owner_q ? i_rsp1_ready : i_rsp0_ready);
        trap     = CHECK_CTL && !ctl_is_legal(ctl_q);
    end

    assign o_req0_ready = accept && !grant_id;
    assign o_req1_ready = accept &&  grant_id;
    assign o_busy       = (state_q != ST_IDLE);

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP, RESP -> IDLE on consume.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_EXEC;
            ST_EXEC:               state_d = ST_RESP;
            ST_RESP: if (rsp_fire) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // State, round-robin pointer and request capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            ctl_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state_q <= state_d;
            if (accept) begin
                last_q  <= grant_id;
                owner_q <= grant_id;
                op1_q   <= grant_id ? i_req1_operand1   : i_req0_operand1;
                op2_q   <= grant_id ? i_req1_operand2   : i_req0_operand2;
                ctl_q   <= grant_id ? i_req1_ALUControl : i_req0_ALUControl;
            end
        end
    end

    ALU u_alu (
        .operand1   (op1_q),
        .operand2   (op2_q),
        .ALUControl (ctl_q),
        .result     (alu_result),
        .zero       (alu_zero),
        .neg        (alu_neg)
    );

    // Capture the ALU outcome (or the trap value) during EXEC; hold it through RESP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            res_q  <= trap ? '0   : alu_result;
            zero_q <= trap ? 1'b1 : alu_zero;
            neg_q  <= trap ? 1'b0 : alu_neg;
            err_q  <= trap;
        end
    end

    // Steer the held response to its owner; the other port reads all zeros.
    always_comb begin
        o_rsp0_valid  = (state_q == ST_RESP) && !owner_q;
        o_rsp1_valid  = (state_q == ST_RESP) &&  owner_q;
        o_rsp0_result = o_rsp0_valid ? res_q : '0;
        o_rsp0_zero   = o_rsp0_valid && zero_q;
        o_rsp0_neg    = o_rsp0_valid && neg_q;
        o_rsp0_err    = o_rsp0_valid && err_q;
        o_rsp1_result = o_rsp1_valid ? res_q : '0;
        o_rsp1_zero   = o_rsp1_valid && zero_q;
        o_rsp1_neg    = o_rsp1_valid && neg_q;
        o_rsp1_err    = o_rsp1_valid && err_q;
    end

endmodule
